// File: rtl/bcd_scan_display.sv
// Time-multiplexed common-anode 7-segment driver for packed BCD digits with frame-coherent snapshots.
// Define BCD_SCAN_LZB_EN to enable leading-zero blanking.
module bcd_scan_display #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);
    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] staging_q, staging_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic                    pending_q, pending_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_done_q, frame_done_d;

    logic                    div_end, idx_end, boundary;
    logic [3:0]              shadow_digit [NUM_DIGITS];
    logic [3:0]              cur_digit;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign shadow_digit[gi] = shadow_q[4*gi +: 4];
    end

`ifdef BCD_SCAN_LZB_EN
    logic [NUM_DIGITS-1:0] lead_zero;
    logic                  zero_run;

    // lead_zero[i] is set when digit i and every digit above it are zero
    always_comb begin
        lead_zero = '0;
        zero_run  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run     = zero_run && (shadow_digit[i] == 4'd0);
            lead_zero[i] = zero_run;
        end
    end
`endif

    always_comb begin
        div_end   = (div_cnt_q == DIV_W'(REFRESH_DIV - 1));
        idx_end   = (idx_q == IDX_W'(NUM_DIGITS - 1));
        boundary  = div_end && idx_end;

        div_cnt_d = div_end ? '0 : div_cnt_q + 1'b1;
        idx_d     = idx_q;
        if (div_end) begin
            idx_d = idx_end ? '0 : idx_q + 1'b1;
        end

        staging_d = staging_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        // A load coinciding with the boundary is fresher than anything staged
        if (boundary) begin
            if (load) begin
                shadow_d = digits_in;
            end else if (pending_q) begin
                shadow_d = staging_q;
            end
            pending_d = 1'b0;
        end else if (load) begin
            staging_d = digits_in;
            pending_d = 1'b1;
        end

        cur_digit = shadow_digit[idx_q];
        an_d      = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q);
        seg_d     = decode(cur_digit);
`ifdef BCD_SCAN_LZB_EN
        if ((idx_q != '0) && lead_zero[idx_q]) begin
            an_d  = '1;
            seg_d = 7'b1111111;
        end
`endif
        frame_done_d = boundary;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q    <= '0;
            idx_q        <= '0;
            staging_q    <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            seg_q        <= 7'b1111111;
            an_q         <= '1;
            frame_done_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            idx_q        <= idx_d;
            staging_q    <= staging_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_bcd_scan_display.sv
// Self-checking bench for bcd_scan_display: directed scenarios plus random loads against a frame-level model.
module tb_bcd_scan_display;
    localparam int N  = 4;
    localparam int R  = 4;
    localparam int NR = N * R;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] digits_in;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;

    // Model: edge index since reset release, value shown this frame, latest load of the current window
    int          e_cnt;
    logic [15:0] shown;
    logic [15:0] win_val;
    bit          win_has;
    logic [6:0]  seg_tab [16];

    always #5 clk = ~clk;

    bcd_scan_display #(.NUM_DIGITS(N), .REFRESH_DIV(R)) dut (
        .clk        (clk),
        .reset      (reset),
        .digits_in  (digits_in),
        .load       (load),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s edge=%0d observed=%h expected=%h", tag, e_cnt, obs, exp);
        end
    endtask

    task automatic step(input bit ld, input logic [15:0] d);
        int         dig;
        logic [3:0] v;
        logic [6:0] exp_seg;
        logic [3:0] exp_an;
        load      = ld;
        digits_in = d;
        @(posedge clk);
        #1;
        dig     = (e_cnt / R) % N;
        v       = 4'(shown >> (4 * dig));
        exp_seg = seg_tab[v];
        exp_an  = ~(4'b0001 << dig);
`ifdef BCD_SCAN_LZB_EN
        if (dig > 0 && (shown >> (4 * dig)) == 16'h0) begin
            exp_seg = 7'h7f;
            exp_an  = 4'hf;
        end
`endif
        chk("an", 16'(an), 16'(exp_an));
        chk("seg", 16'(seg), 16'(exp_seg));
        chk("frame_done", 16'(frame_done), 16'(e_cnt % NR == NR - 1));
        if (ld) begin
            $display("load edge=%0d data=%h shown=%h", e_cnt, d, shown);
            win_val = d;
            win_has = 1'b1;
        end
        if (e_cnt % NR == NR - 1 && win_has) begin
            shown   = win_val;
            win_has = 1'b0;
        end
        e_cnt++;
        load = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        load  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            chk("rst_an", 16'(an), 16'hf);
            chk("rst_seg", 16'(seg), 16'h7f);
            chk("rst_frame_done", 16'(frame_done), 16'h0);
        end
        $display("reset cycles=%0d", n);
        reset   = 1'b0;
        e_cnt   = 0;
        shown   = 16'h0;
        win_val = 16'h0;
        win_has = 1'b0;
    endtask

    task automatic align_frame_start();
        while (e_cnt % NR != 0) step(1'b0, 16'h0);
    endtask

    initial begin
        reset     = 1'b1;
        load      = 1'b0;
        digits_in = 16'h0;
        seg_tab   = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                      7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                      7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

        do_reset(12);
        repeat (32) step(1'b0, 16'h0);

        align_frame_start();
        step(1'b1, 16'h0937);
        repeat (40) step(1'b0, 16'h0);

        align_frame_start();
        step(1'b1, 16'h1111);
        repeat (5) step(1'b0, 16'h0);
        step(1'b1, 16'h2222);
        repeat (40) step(1'b0, 16'h0);

        align_frame_start();
        step(1'b1, 16'h1234);
        while (e_cnt % NR != NR - 1) step(1'b0, 16'h0);
        step(1'b1, 16'h5555);
        repeat (20) step(1'b0, 16'h0);

        align_frame_start();
        step(1'b1, 16'hA0F9);
        repeat (24) step(1'b0, 16'h0);
        repeat (6) step(1'b0, 16'h0);
        step(1'b1, 16'h7777);
        do_reset(3);
        repeat (20) step(1'b0, 16'h0);

        align_frame_start();
        step(1'b1, 16'h0040);
        repeat (32) step(1'b0, 16'h0);
        step(1'b1, 16'h0000);
        repeat (32) step(1'b0, 16'h0);

        repeat (600) step($urandom_range(0, 3) == 0, 16'($urandom));
        step(1'b1, 16'h0300);
        repeat (40) step(1'b0, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
